led_sweep_sequencer: RTL and testbench

Generates the 4-bit LED index that drives the board's registered 4-to-16 one-hot LED decoder. The index is connected directly to the decoder's 4-bit value input.
- A prescaler divides the 100 MHz system clock into step ticks.
- On each tick the index advances according to the selected mode: count up, count down, bounce (Larson sweep) or hold.
- Supports synchronous preload and pause.
- Emits a one-cycle step strobe for downstream consumers.

---
 rtl/led_sweep_sequencer.sv | 137 +++++++++++++
 tb/tb_led_sweep_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/led_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// led_sweep_sequencer
//
// Produces the 4-bit LED index fed to the board's registered 4-to-16 one-hot
// LED decoder. A prescaler divides the system clock into step ticks; on each
// tick the index moves according to the selected mode (up-wrap, down-wrap,
// bounce/Larson sweep, or hold). Supports synchronous preload and pausing.
//
// Ports:
//   i_Clk         system clock, rising edge
//   i_Rst_n       asynchronous active-low reset
//   i_Enable      1 = prescaler runs, 0 = prescaler and index freeze
//   i_Mode        00 up-wrap, 01 down-wrap, 10 bounce, 11 hold
//   i_Load        synchronous preload strobe (wins over a coincident tick)
//   i_Load_Value  index loaded when i_Load = 1
//   o_LED_Value   current LED index (registered)
//   o_Step        one-cycle pulse in the cycle the index changes due to a step
//   o_Dir         direction state, 0 = UP, 1 = DOWN
// -----------------------------------------------------------------------------
module led_sweep_sequencer #(
  parameter int CLKS_PER_STEP = 10000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Enable,
  input  logic [1:0] i_Mode,
  input  logic       i_Load,
  input  logic [3:0] i_Load_Value,
  output logic [3:0] o_LED_Value,
  output logic       o_Step,
  output logic       o_Dir
);

  localparam int CNT_W = $clog2(CLKS_PER_STEP);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_STEP - 1);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  logic [CNT_W-1:0] r_Prescaler;
  logic [3:0]       r_LED_Value;
  dir_t             r_Dir;
  logic             r_Step;

  logic [CNT_W-1:0] w_Prescaler_Next;
  logic [3:0]       w_LED_Value_Next;
  dir_t             w_Dir_Next;
  logic             w_Step_Next;
  logic             w_Tick;
  mode_t            w_Mode;

  assign w_Mode = mode_t'(i_Mode);
  assign w_Tick = i_Enable && (r_Prescaler == PRE_LAST);

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Prescaler <= '0;
      r_LED_Value <= 4'd0;
      r_Dir       <= DIR_UP;
      r_Step      <= 1'b0;
    end else begin
      r_Prescaler <= w_Prescaler_Next;
      r_LED_Value <= w_LED_Value_Next;
      r_Dir       <= w_Dir_Next;
      r_Step      <= w_Step_Next;
    end
  end

  // Next-state logic: load > tick > hold.
  always_comb begin
    w_Prescaler_Next = r_Prescaler;
    w_LED_Value_Next = r_LED_Value;
    w_Dir_Next       = r_Dir;
    w_Step_Next      = 1'b0;

    // Paused prescaler keeps its count so resume continues mid-period.
    if (i_Enable) begin
      w_Prescaler_Next = w_Tick ? '0 : r_Prescaler + 1'b1;
    end

    if (i_Load) begin
      w_LED_Value_Next = i_Load_Value;
      w_Prescaler_Next = '0;
    end else if (w_Tick) begin
      case (w_Mode)
        MODE_UP: begin
          w_LED_Value_Next = r_LED_Value + 4'd1;
          w_Dir_Next       = DIR_UP;
          w_Step_Next      = 1'b1;
        end
        MODE_DOWN: begin
          w_LED_Value_Next = r_LED_Value - 4'd1;
          w_Dir_Next       = DIR_DOWN;
          w_Step_Next      = 1'b1;
        end
        MODE_BOUNCE: begin
          // Turn around at the endpoints so each end is lit for one step only.
          w_Step_Next = 1'b1;
          if (r_Dir == DIR_UP) begin
            if (r_LED_Value == 4'd15) begin
              w_LED_Value_Next = 4'd14;
              w_Dir_Next       = DIR_DOWN;
            end else begin
              w_LED_Value_Next = r_LED_Value + 4'd1;
            end
          end else begin
            if (r_LED_Value == 4'd0) begin
              w_LED_Value_Next = 4'd1;
              w_Dir_Next       = DIR_UP;
            end else begin
              w_LED_Value_Next = r_LED_Value - 4'd1;
            end
          end
        end
        default: begin
          // Hold: tick is consumed silently.
          w_Step_Next = 1'b0;
        end
      endcase
    end
  end

  assign o_LED_Value = r_LED_Value;
  assign o_Step      = r_Step;
  assign o_Dir       = r_Dir;

endmodule

// File: tb/tb_led_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_sweep_sequencer
//
// Self-checking bench for led_sweep_sequencer with CLKS_PER_STEP = 4. A
// behavioural model predicts each cycle's outputs; the prediction is pushed to
// a scoreboard queue when the inputs are driven and popped and compared one
// step after the following rising edge. Directed checks cover the scenario
// expectations (endpoints, collisions, pause, async reset).
// -----------------------------------------------------------------------------
module tb_led_sweep_sequencer;

  localparam int CPS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       ld = 1'b0;
  logic [3:0] lv = 4'd0;
  logic [3:0] led;
  logic       stp;
  logic       dir;

  always #5 clk = ~clk;

  led_sweep_sequencer #(.CLKS_PER_STEP(CPS)) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Enable     (en),
    .i_Mode       (mode),
    .i_Load       (ld),
    .i_Load_Value (lv),
    .o_LED_Value  (led),
    .o_Step       (stp),
    .o_Dir        (dir)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard entries: {value[3:0], dir, step}.
  logic [5:0] sb_q[$];

  int m_pre;
  int m_val;
  bit m_dir;
  bit m_step;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pre  = 0;
    m_val  = 0;
    m_dir  = 1'b0;
    m_step = 1'b0;
    sb_q.delete();
  endtask

  // Predict the state after the next rising edge from the current inputs.
  task automatic model_push();
    bit tick;
    int delta;
    tick = en && (m_pre == CPS - 1);
    if (ld) begin
      m_val  = int'(lv);
      m_pre  = 0;
      m_step = 1'b0;
    end else begin
      if (en) m_pre = (m_pre + 1) % CPS;
      m_step = 1'b0;
      if (tick) begin
        if (mode == 2'b00) begin
          m_val = (m_val + 1) % 16; m_dir = 1'b0; m_step = 1'b1;
        end else if (mode == 2'b01) begin
          m_val = (m_val + 15) % 16; m_dir = 1'b1; m_step = 1'b1;
        end else if (mode == 2'b10) begin
          delta = m_dir ? -1 : 1;
          if (m_val + delta > 15 || m_val + delta < 0) begin
            m_dir = ~m_dir;
            delta = -delta;
          end
          m_val  = m_val + delta;
          m_step = 1'b1;
        end
      end
    end
    sb_q.push_back({4'(m_val), m_dir, m_step});
  endtask

  // One transaction: predict, clock, compare against the scoreboard.
  task automatic cyc(input string tag);
    logic [5:0] e;
    model_push();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk(tag, {26'd0, led, dir, stp}, {26'd0, e});
    $display("txn %s: led=%0d dir=%0b step=%0b", tag, led, dir, stp);
  endtask

  initial begin
    int k;
    int ev;

    // 1. Reset and idle.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", {28'd0, led}, 32'd0);
    chk("rst_dir", {31'd0, dir}, 32'd0);
    chk("rst_step", {31'd0, stp}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc("idle");
    chk("idle_led", {28'd0, led}, 32'd0);

    // 2. Up-wrap from 14.
    ld = 1'b1; lv = 4'd14; mode = 2'b00; en = 1'b1;
    cyc("t2_load");
    chk("t2_loaded", {28'd0, led}, 32'd14);
    ld = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc("t2_run");
      chk("t2_step", {31'd0, stp}, (i % 4 == 0) ? 32'd1 : 32'd0);
      if (i == 4) chk("t2_v15", {28'd0, led}, 32'd15);
      if (i == 8) chk("t2_v0", {28'd0, led}, 32'd0);
    end

    // 3. Bounce endpoints from 14 going UP.
    ld = 1'b1; lv = 4'd14; mode = 2'b10;
    cyc("t3_load");
    ld = 1'b0;
    for (k = 0; k < 17; k++) begin
      repeat (3) cyc("t3_wait");
      cyc("t3_step");
      ev = (k == 0) ? 15 : (k <= 15) ? 15 - k : 1;
      chk("t3_val", {28'd0, led}, 32'(ev));
      chk("t3_dir", {31'd0, dir}, (k >= 1 && k <= 15) ? 32'd1 : 32'd0);
    end

    // 4. Load colliding with a tick (prescaler = 3).
    repeat (3) cyc("t4_wait");
    ld = 1'b1; lv = 4'd5;
    cyc("t4_load");
    chk("t4_val", {28'd0, led}, 32'd5);
    chk("t4_step", {31'd0, stp}, 32'd0);
    ld = 1'b0;
    repeat (3) cyc("t4_gap");
    chk("t4_still5", {28'd0, led}, 32'd5);
    cyc("t4_next");
    chk("t4_v6", {28'd0, led}, 32'd6);
    chk("t4_step6", {31'd0, stp}, 32'd1);

    // 5. Pause at prescaler = 2, resume, then hold mode.
    repeat (2) cyc("t5_pre");
    en = 1'b0;
    repeat (10) cyc("t5_pause");
    chk("t5_paused", {28'd0, led}, 32'd6);
    en = 1'b1;
    cyc("t5_res1");
    chk("t5_res1_step", {31'd0, stp}, 32'd0);
    cyc("t5_res2");
    chk("t5_res2_step", {31'd0, stp}, 32'd1);
    chk("t5_res2_val", {28'd0, led}, 32'd7);
    mode = 2'b11;
    for (int i = 0; i < 12; i++) begin
      cyc("t5_hold");
      chk("t5_hold_step", {31'd0, stp}, 32'd0);
      chk("t5_hold_val", {28'd0, led}, 32'd7);
    end

    // 6. Async reset mid-sweep at value 9, DOWN.
    ld = 1'b1; lv = 4'd10; mode = 2'b01;
    cyc("t6_load");
    ld = 1'b0;
    repeat (4) cyc("t6_down");
    chk("t6_pre_val", {28'd0, led}, 32'd9);
    chk("t6_pre_dir", {31'd0, dir}, 32'd1);
    mode = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_val", {28'd0, led}, 32'd0);
    chk("t6_async_dir", {31'd0, dir}, 32'd0);
    chk("t6_async_step", {31'd0, stp}, 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc("t6_restart");
      if (i == 4) chk("t6_v1", {28'd0, led}, 32'd1);
      if (i == 8) chk("t6_v2", {28'd0, led}, 32'd2);
    end
    chk("t6_dir_up", {31'd0, dir}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
